// File: rtl/zbt_acc_packer_pkg.sv
// rtl/zbt_acc_packer_pkg.sv - shared states, defaults and lane layout for the ZBT accumulator packer
package zbt_acc_packer_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCUM  = 2'd1,
      ROUND  = 2'd2,
      OUTPUT = 2'd3
   } state_t;

   localparam int ACC_W_DEF  = 22;
   localparam int SHIFT_DEF  = 7;
   localparam int MAX_TAPS   = 16;
   localparam int TAP_CNT_W  = 5;
   localparam int NUM_LANES  = 4;

   localparam int LANE_A_LSB = 24;
   localparam int LANE_B_LSB = 16;
   localparam int LANE_C_LSB = 8;
   localparam int LANE_D_LSB = 0;

   // Lane index 0 is A (most significant byte), 3 is D.
   function automatic int lane_lsb(input int lane);
      case (lane)
         0:       return LANE_A_LSB;
         1:       return LANE_B_LSB;
         2:       return LANE_C_LSB;
         default: return LANE_D_LSB;
      endcase
   endfunction

endpackage

// File: rtl/zbt_lane_acc.sv
// rtl/zbt_lane_acc.sv - one lane: signed accumulate, round, shift and clip to an unsigned byte
module zbt_lane_acc
   import zbt_acc_packer_pkg::*;
#(
   parameter int ACC_W = ACC_W_DEF,
   parameter int SHIFT = SHIFT_DEF
) (
   input  logic        clock,
   input  logic        resetn,
   input  logic        load,
   input  logic        accum,
   input  logic        sub,
   input  logic        capture,
   input  logic [15:0] x_in,
   output logic [7:0]  byte_out,
   output logic        clip
);

   localparam logic [ACC_W:0] HALF = (ACC_W+1)'(1) << (SHIFT - 1);

   logic        [ACC_W-1:0] acc;
   logic        [ACC_W-1:0] x_ext;
   logic        [ACC_W-1:0] addend;
   logic signed [ACC_W:0]   biased;
   logic signed [ACC_W:0]   rounded;
   logic                    is_neg;
   logic                    is_big;
   logic        [7:0]       sat_byte;

   assign x_ext  = {{(ACC_W-16){1'b0}}, x_in};
   assign addend = sub ? (~x_ext + 1'b1) : x_ext;

   // One extra bit keeps the rounding bias from wrapping near the top of the range.
   assign biased  = $signed({acc[ACC_W-1], acc} + HALF);
   assign rounded = biased >>> SHIFT;
   assign is_neg  = rounded[ACC_W];
   assign is_big  = !is_neg && (|rounded[ACC_W-1:8]);

   always_comb begin
      sat_byte = rounded[7:0];
      if (is_neg) begin
         sat_byte = 8'h00;
      end else if (is_big) begin
         sat_byte = 8'hFF;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         acc      <= '0;
         byte_out <= '0;
         clip     <= 1'b0;
      end else begin
         if (load) begin
            acc <= addend;
         end else if (accum) begin
            acc <= acc + addend;
         end
         if (capture) begin
            byte_out <= sat_byte;
            clip     <= is_neg || is_big;
         end
      end
   end

endmodule

// File: rtl/zbt_acc_packer.sv
// rtl/zbt_acc_packer.sv - four-lane multiply-accumulate packer feeding a ZBT writer with one 32-bit word per group
module zbt_acc_packer
   import zbt_acc_packer_pkg::*;
#(
   parameter int ACC_W = ACC_W_DEF,
   parameter int SHIFT = SHIFT_DEF
) (
   input  logic        clock,
   input  logic        resetn,
   input  logic        prod_valid,
   output logic        prod_ready,
   input  logic [15:0] a_in,
   input  logic [15:0] b_in,
   input  logic [15:0] c_in,
   input  logic [15:0] d_in,
   input  logic        sign_in,
   input  logic        last_in,
   output logic [31:0] word_out,
   output logic [3:0]  clip_out,
   output logic        tap_ovf,
   output logic        word_valid,
   input  logic        word_ready
);

   state_t                 state_q;
   state_t                 state_d;
   logic                   armed;
   logic [TAP_CNT_W-1:0]   tap_cnt;
   logic                   accept;
   logic                   lane_load;
   logic                   lane_accum;
   logic                   lane_capture;
   logic [15:0]            lane_x    [NUM_LANES];
   logic [7:0]             lane_byte [NUM_LANES];
   logic                   lane_clip [NUM_LANES];

   assign lane_x[0] = a_in;
   assign lane_x[1] = b_in;
   assign lane_x[2] = c_in;
   assign lane_x[3] = d_in;

   // armed holds prod_ready low until the first edge after reset release.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         armed <= 1'b0;
      end else begin
         armed <= 1'b1;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      prod_ready   = 1'b0;
      word_valid   = 1'b0;
      lane_capture = 1'b0;
      case (state_q)
         IDLE: begin
            prod_ready = armed;
            if (prod_valid && armed) begin
               state_d = last_in ? ROUND : ACCUM;
            end
         end
         ACCUM: begin
            prod_ready = armed;
            if (prod_valid && armed && last_in) begin
               state_d = ROUND;
            end
         end
         ROUND: begin
            lane_capture = 1'b1;
            state_d      = OUTPUT;
         end
         OUTPUT: begin
            word_valid = 1'b1;
            if (word_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign accept     = prod_valid && prod_ready;
   assign lane_load  = accept && (state_q == IDLE);
   assign lane_accum = accept && (state_q == ACCUM);

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         tap_cnt <= '0;
         tap_ovf <= 1'b0;
      end else begin
         if (lane_load) begin
            tap_cnt <= TAP_CNT_W'(1);
         end else if (lane_accum && (tap_cnt <= TAP_CNT_W'(MAX_TAPS))) begin
            tap_cnt <= tap_cnt + 1'b1;
         end
         if (lane_capture) begin
            tap_ovf <= (tap_cnt > TAP_CNT_W'(MAX_TAPS));
         end
      end
   end

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      zbt_lane_acc #(
         .ACC_W (ACC_W),
         .SHIFT (SHIFT)
      ) u_lane (
         .clock    (clock),
         .resetn   (resetn),
         .load     (lane_load),
         .accum    (lane_accum),
         .sub      (sign_in),
         .capture  (lane_capture),
         .x_in     (lane_x[i]),
         .byte_out (lane_byte[i]),
         .clip     (lane_clip[i])
      );
   end

   always_comb begin
      word_out = '0;
      clip_out = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         word_out[lane_lsb(i) +: 8] = lane_byte[i];
         clip_out[NUM_LANES-1-i]    = lane_clip[i];
      end
   end

endmodule

// File: tb/tb_zbt_acc_packer.sv
// tb/tb_zbt_acc_packer.sv - scoreboard bench for the ZBT accumulator packer
module tb_zbt_acc_packer;

   localparam int ACC_W = 22;
   localparam int SHIFT = 7;

   typedef struct {
      logic [31:0] word;
      logic [3:0]  clip;
      logic        ovf;
   } exp_t;

   logic        clock = 1'b0;
   logic        resetn = 1'b0;
   logic        prod_valid = 1'b0;
   logic        prod_ready;
   logic [15:0] a_in = '0, b_in = '0, c_in = '0, d_in = '0;
   logic        sign_in = 1'b0;
   logic        last_in = 1'b0;
   logic [31:0] word_out;
   logic [3:0]  clip_out;
   logic        tap_ovf;
   logic        word_valid;
   logic        word_ready = 1'b1;

   int     n_checks = 0;
   int     n_errors = 0;
   exp_t   exp_q[$];
   longint m_acc[4];
   int     m_cnt = 0;

   zbt_acc_packer #(.ACC_W(ACC_W), .SHIFT(SHIFT)) dut (
      .clock      (clock),
      .resetn     (resetn),
      .prod_valid (prod_valid),
      .prod_ready (prod_ready),
      .a_in       (a_in),
      .b_in       (b_in),
      .c_in       (c_in),
      .d_in       (d_in),
      .sign_in    (sign_in),
      .last_in    (last_in),
      .word_out   (word_out),
      .clip_out   (clip_out),
      .tap_ovf    (tap_ovf),
      .word_valid (word_valid),
      .word_ready (word_ready)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic void model_lane(input longint acc, output logic [7:0] b, output logic c);
      longint w, r;
      w = acc & ((longint'(1) << ACC_W) - 1);
      if (w >= (longint'(1) << (ACC_W - 1))) w = w - (longint'(1) << ACC_W);
      r = (w + (longint'(1) << (SHIFT - 1))) >>> SHIFT;
      if (r < 0) begin
         b = 8'h00; c = 1'b1;
      end else if (r > 255) begin
         b = 8'hFF; c = 1'b1;
      end else begin
         b = r[7:0]; c = 1'b0;
      end
   endfunction

   task automatic push_expected();
      exp_t e;
      logic [7:0] b;
      logic c;
      for (int i = 0; i < 4; i++) begin
         model_lane(m_acc[i], b, c);
         e.word[31-8*i -: 8] = b;
         e.clip[3-i] = c;
      end
      e.ovf = (m_cnt > 16);
      exp_q.push_back(e);
   endtask

   // Drive one beat, wait for it to be accepted, then update the model.
   task automatic beat(input logic [15:0] a, b, c, d, input logic sgn, input logic last);
      int n;
      longint xs[4];
      a_in = a; b_in = b; c_in = c; d_in = d; sign_in = sgn; last_in = last;
      prod_valid = 1'b1;
      n = 0;
      while (!prod_ready && n < 50) begin
         @(posedge clock); #1;
         n++;
      end
      if (!prod_ready) chk("accept_timeout", 32'd1, 32'd0);
      @(posedge clock); #1;
      prod_valid = 1'b0;
      xs[0] = a; xs[1] = b; xs[2] = c; xs[3] = d;
      for (int i = 0; i < 4; i++) begin
         if (m_cnt == 0) m_acc[i] = sgn ? -xs[i] : xs[i];
         else            m_acc[i] = m_acc[i] + (sgn ? -xs[i] : xs[i]);
      end
      m_cnt = (m_cnt < 17) ? m_cnt + 1 : 17;
      if (last) begin
         push_expected();
         m_cnt = 0;
      end
   endtask

   task automatic model_clear();
      m_cnt = 0;
      for (int i = 0; i < 4; i++) m_acc[i] = 0;
   endtask

   // Compare on the half-cycle before the edge that completes the handshake.
   always @(negedge clock) begin
      if (resetn && word_valid && word_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_word", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("word_out", word_out, e.word);
            chk("clip_out", {28'd0, clip_out}, {28'd0, e.clip});
            chk("tap_ovf", {31'd0, tap_ovf}, {31'd0, e.ovf});
            chk("ready_in_output", {31'd0, prod_ready}, 32'd0);
         end
      end
   end

   initial begin
      int n;
      logic [31:0] held;
      model_clear();

      #3;
      chk("rst_prod_ready", {31'd0, prod_ready}, 32'd0);
      chk("rst_word_valid", {31'd0, word_valid}, 32'd0);
      chk("rst_word_out", word_out, 32'd0);
      chk("rst_clip_tap", {27'd0, tap_ovf, clip_out}, 32'd0);
      #9 resetn = 1'b1;
      @(posedge clock); #1;
      chk("ready_after_rst", {31'd0, prod_ready}, 32'd1);

      // Single tap midscale with latency checks.
      beat(16'd16320, 0, 0, 0, 1'b0, 1'b1);
      chk("lat_t1_valid", {31'd0, word_valid}, 32'd0);
      @(posedge clock); #1;
      chk("lat_t2_valid", {31'd0, word_valid}, 32'd1);
      @(posedge clock); #1;
      chk("lat_t3_ready", {31'd0, prod_ready}, 32'd1);

      // Negative result clips to 0; two taps clip to 255; add/sub pair.
      beat(16'd100, 0, 0, 0, 1'b1, 1'b1);
      beat(16'd32640, 0, 0, 0, 1'b0, 1'b0);
      beat(16'd32640, 0, 0, 0, 1'b0, 1'b1);
      beat(16'd1280, 0, 0, 0, 1'b0, 1'b0);
      beat(16'd256, 0, 0, 0, 1'b1, 1'b1);
      beat(16'd640, 16'd1000, 16'd65535, 16'd63, 1'b0, 1'b1);

      // Backpressure: output held, beats offered and ignored.
      n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         @(posedge clock); #1;
         n++;
      end
      word_ready = 1'b0;
      beat(16'd2560, 16'd128, 16'd0, 16'd300, 1'b0, 1'b1);
      @(posedge clock); #1;
      held = (exp_q.size() != 0) ? exp_q[0].word : 32'hDEADBEEF;
      for (int k = 0; k < 5; k++) begin
         prod_valid = 1'b1;
         a_in = 16'($urandom);
         last_in = k[0];
         chk("bp_valid", {31'd0, word_valid}, 32'd1);
         chk("bp_word_stable", word_out, held);
         chk("bp_ready_low", {31'd0, prod_ready}, 32'd0);
         @(posedge clock); #1;
      end
      prod_valid = 1'b0;
      word_ready = 1'b1;
      @(posedge clock); #1;
      chk("bp_back_idle", {31'd0, prod_ready}, 32'd1);
      chk("bp_valid_low", {31'd0, word_valid}, 32'd0);

      // Reset mid-group discards partial sums.
      beat(16'd5000, 16'd5000, 16'd5000, 16'd5000, 1'b0, 1'b0);
      beat(16'd7000, 16'd7000, 16'd7000, 16'd7000, 1'b0, 1'b0);
      resetn = 1'b0;
      model_clear();
      #2;
      chk("midrst_ready", {31'd0, prod_ready}, 32'd0);
      @(negedge clock);
      resetn = 1'b1;
      @(posedge clock); #1;
      beat(0, 0, 0, 16'd640, 1'b0, 1'b1);

      // Tap-count boundary: 16 taps no overflow, 17 taps overflow.
      for (int k = 0; k < 16; k++) beat(0, 0, 0, 0, 1'b0, k == 15);
      for (int k = 0; k < 17; k++) beat(0, 0, 0, 0, 1'b0, k == 16);
      for (int k = 0; k < 20; k++) beat(16'd50, 16'd9, 16'd0, 16'd7, k[0], k == 19);

      // Random groups.
      for (int g = 0; g < 6; g++) begin
         int taps;
         taps = $urandom_range(1, 4);
         for (int k = 0; k < taps; k++)
            beat(16'($urandom), 16'($urandom_range(0, 4000)), 16'($urandom), 16'($urandom_range(0, 255)),
                 1'($urandom), k == taps - 1);
      end

      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(posedge clock); #1;
         n++;
      end
      chk("queue_drained", exp_q.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
